sdram_mp: RTL and testbench

- Parametrised, multi-channel successor of the single-port 8-cycle SDRAM controller.
- Serves NCH independent client channels through a req/ack handshake.
- Each sync-aligned access window carries one access, granted round-robin, or one auto-refresh.
- Adds configurable timing (tRCD, CL, window length), a forced-refresh guarantee under continuous load, and split tri-state DQ pins for the top-level pad wrapper.

---
 rtl/sdram_mp.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mp.sv
// Multi-channel SDRAM controller. Each sync-aligned window carries one round-robin access or one auto-refresh.
// Pins are registered, so a command decided while the stage counter reads S appears on the pins during stage S+1.
module sdram_mp #(
    parameter int NCH          = 3,
    parameter int AW           = 24,
    parameter int CYCLE_LEN    = 8,
    parameter int TRCD         = 2,
    parameter int CL           = 2,
    parameter int INIT_WINDOWS = 31,
    parameter int REFRESH_MAX  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*16-1:0] ch_din,
    input  logic [NCH*2-1:0]  ch_ds,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_valid,
    output logic [15:0]       dout,
    output logic [12:0]       sd_addr,
    output logic [1:0]        sd_ba,
    output logic [1:0]        sd_dqm,
    output logic              sd_cs_n,
    output logic              sd_ras_n,
    output logic              sd_cas_n,
    output logic              sd_we_n,
    output logic [15:0]       sd_dq_o,
    output logic              sd_dq_oe,
    input  logic [15:0]       sd_dq_i
);

    localparam int SW = $clog2(CYCLE_LEN);
    localparam int IW = ($clog2(INIT_WINDOWS + 1) < 4) ? 4 : $clog2(INIT_WINDOWS + 1);
    localparam int RW = $clog2(REFRESH_MAX + 1);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [SW-1:0] S_CMD  = SW'(1);
    localparam logic [SW-1:0] S_CAS  = SW'(1 + TRCD);
    localparam logic [SW-1:0] S_RD   = SW'(1 + TRCD + CL + 1);
    localparam logic [SW-1:0] S_LAST = SW'(CYCLE_LEN - 1);

    // Encoded as {cs_n, ras_n, cas_n, we_n}.
    typedef enum logic [3:0] {
        CMD_NOP       = 4'b0111,
        CMD_ACTIVE    = 4'b0011,
        CMD_READ      = 4'b0101,
        CMD_WRITE     = 4'b0100,
        CMD_PRECHARGE = 4'b0010,
        CMD_REFRESH   = 4'b0001,
        CMD_LOAD_MODE = 4'b0000
    } cmd_e;

    logic            sync_q;
    logic            syncEdge;
    logic [SW-1:0]   stage_q;
    logic [SW-1:0]   stage_d;

    cmd_e            cmd_q;
    logic [12:0]     sdAddr_q;
    logic [1:0]      sdBa_q;
    logic [1:0]      sdDqm_q;
    logic [15:0]     sdDqO_q;
    logic            sdDqOe_q;
    logic [NCH-1:0]  chAck_q;
    logic [NCH-1:0]  chValid_q;
    logic [15:0]     dout_q;

    logic [IW-1:0]   initCnt_q;
    logic [PW-1:0]   rrPtr_q;
    logic [RW-1:0]   noRefCnt_q;
    logic            busy_q;
    logic            we_q;
    logic [15:0]     din_q;
    logic [1:0]      ds_q;
    logic [8:0]      col_q;
    logic [PW-1:0]   gnt_q;

    logic            gntFound;
    logic [PW-1:0]   gntIdx;
    logic [AW-1:0]   gntAddr;

    assign syncEdge = sync & ~sync_q;

    always_comb begin
        stage_d = stage_q;
        if (syncEdge) begin
            stage_d = S_CMD;
        end else if (stage_q == S_LAST) begin
            stage_d = '0;
        end else if (stage_q != '0) begin
            stage_d = stage_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            sync_q  <= sync;
            stage_q <= stage_d;
        end
    end

    // Round-robin search starts just after the last channel served.
    always_comb begin
        gntFound = 1'b0;
        gntIdx   = rrPtr_q;
        for (int k = 1; k <= NCH; k++) begin
            if (!gntFound && ch_req[(int'(rrPtr_q) + k) % NCH]) begin
                gntFound = 1'b1;
                gntIdx   = PW'((int'(rrPtr_q) + k) % NCH);
            end
        end
    end

    assign gntAddr = ch_addr[int'(gntIdx)*AW +: AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= CMD_NOP;
            sdAddr_q   <= '0;
            sdBa_q     <= '0;
            sdDqm_q    <= 2'b11;
            sdDqO_q    <= '0;
            sdDqOe_q   <= 1'b0;
            chAck_q    <= '0;
            chValid_q  <= '0;
            dout_q     <= '0;
            initCnt_q  <= IW'(INIT_WINDOWS);
            rrPtr_q    <= PW'(NCH - 1);
            noRefCnt_q <= '0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= '0;
            ds_q       <= '0;
            col_q      <= '0;
            gnt_q      <= '0;
        end else begin
            cmd_q     <= CMD_NOP;
            sdDqm_q   <= 2'b11;
            sdDqOe_q  <= 1'b0;
            chAck_q   <= '0;
            chValid_q <= '0;

            // A new sync edge abandons whatever the current window was doing.
            if (syncEdge) begin
                busy_q <= 1'b0;
            end else if (stage_q == S_CMD) begin
                busy_q <= 1'b0;
                if (initCnt_q != '0) begin
                    initCnt_q <= initCnt_q - 1'b1;
                    if (initCnt_q == IW'(13)) begin
                        cmd_q    <= CMD_PRECHARGE;
                        sdAddr_q <= 13'h0400;
                    end else if (initCnt_q >= IW'(3) && initCnt_q <= IW'(12)) begin
                        cmd_q <= CMD_REFRESH;
                    end else if (initCnt_q == IW'(2)) begin
                        cmd_q    <= CMD_LOAD_MODE;
                        sdAddr_q <= {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b000};
                    end
                end else if (noRefCnt_q == RW'(REFRESH_MAX - 1) || !gntFound) begin
                    cmd_q      <= CMD_REFRESH;
                    noRefCnt_q <= '0;
                end else begin
                    chAck_q[gntIdx] <= 1'b1;
                    rrPtr_q         <= gntIdx;
                    if (noRefCnt_q < RW'(REFRESH_MAX - 1)) begin
                        noRefCnt_q <= noRefCnt_q + 1'b1;
                    end
                    cmd_q    <= CMD_ACTIVE;
                    sdBa_q   <= gntAddr[10:9];
                    sdAddr_q <= 13'(gntAddr >> 11);
                    busy_q   <= 1'b1;
                    gnt_q    <= gntIdx;
                    we_q     <= ch_we[gntIdx];
                    din_q    <= ch_din[int'(gntIdx)*16 +: 16];
                    ds_q     <= ch_ds[int'(gntIdx)*2 +: 2];
                    col_q    <= gntAddr[8:0];
                end
            end else if (stage_q == S_CAS && busy_q) begin
                sdAddr_q <= {2'b00, 1'b1, 1'b0, col_q};
                if (we_q) begin
                    cmd_q    <= CMD_WRITE;
                    sdDqm_q  <= ~ds_q;
                    sdDqO_q  <= din_q;
                    sdDqOe_q <= 1'b1;
                end else begin
                    cmd_q   <= CMD_READ;
                    sdDqm_q <= 2'b00;
                end
            end else if (stage_q == S_RD && busy_q && !we_q) begin
                dout_q           <= sd_dq_i;
                chValid_q[gnt_q] <= 1'b1;
            end
        end
    end

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
    assign sd_addr  = sdAddr_q;
    assign sd_ba    = sdBa_q;
    assign sd_dqm   = sdDqm_q;
    assign sd_dq_o  = sdDqO_q;
    assign sd_dq_oe = sdDqOe_q;
    assign ch_ack   = chAck_q;
    assign ch_valid = chValid_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_sdram_mp.sv
// Directed bench for sdram_mp: init sequence, read, masked write, round-robin with forced refresh, mid-window reset.
// Snapshot n of a window holds the pins while the stage counter reads n, i.e. decisions made at stage n-1.
module tb_sdram_mp;

    localparam int NCH = 3;
    localparam int AW  = 24;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              sync;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*16-1:0] ch_din;
    logic [NCH*2-1:0]  ch_ds;
    logic [NCH-1:0]    ch_ack;
    logic [NCH-1:0]    ch_valid;
    logic [15:0]       dout;
    logic [12:0]       sd_addr;
    logic [1:0]        sd_ba;
    logic [1:0]        sd_dqm;
    logic              sd_cs_n;
    logic              sd_ras_n;
    logic              sd_cas_n;
    logic              sd_we_n;
    logic [15:0]       sd_dq_o;
    logic              sd_dq_oe;
    logic [15:0]       sd_dq_i;

    int total = 0;
    int bad   = 0;

    logic [3:0]     snapCmd   [1:8];
    logic [12:0]    snapAddr  [1:8];
    logic [1:0]     snapBa    [1:8];
    logic [1:0]     snapDqm   [1:8];
    logic           snapOe    [1:8];
    logic [15:0]    snapDqo   [1:8];
    logic [15:0]    snapDout  [1:8];
    logic [NCH-1:0] snapAck   [1:8];
    logic [NCH-1:0] snapValid [1:8];
    logic [NCH-1:0] ackOr;
    logic [NCH-1:0] validOr;
    logic [15:0]    rdData;
    logic [2:0]     rrExp [0:15];

    always #5 clk = ~clk;

    sdram_mp dut (
        .clk      (clk),
        .reset    (reset),
        .sync     (sync),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_din   (ch_din),
        .ch_ds    (ch_ds),
        .ch_ack   (ch_ack),
        .ch_valid (ch_valid),
        .dout     (dout),
        .sd_addr  (sd_addr),
        .sd_ba    (sd_ba),
        .sd_dqm   (sd_dqm),
        .sd_cs_n  (sd_cs_n),
        .sd_ras_n (sd_ras_n),
        .sd_cas_n (sd_cas_n),
        .sd_we_n  (sd_we_n),
        .sd_dq_o  (sd_dq_o),
        .sd_dq_oe (sd_dq_oe),
        .sd_dq_i  (sd_dq_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic capture(input int n);
        snapCmd[n]   = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
        snapAddr[n]  = sd_addr;
        snapBa[n]    = sd_ba;
        snapDqm[n]   = sd_dqm;
        snapOe[n]    = sd_dq_oe;
        snapDqo[n]   = sd_dq_o;
        snapDout[n]  = dout;
        snapAck[n]   = ch_ack;
        snapValid[n] = ch_valid;
        ackOr        = ackOr | ch_ack;
        validOr      = validOr | ch_valid;
    endtask

    // One full window; rdData is presented on sd_dq_i only while the stage counter reads 6.
    task automatic applyStimulus();
        ackOr   = '0;
        validOr = '0;
        @(posedge clk);
        #1 sync = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;
        sd_dq_i = 16'h0000;
        capture(1);
        for (int n = 2; n <= 8; n++) begin
            @(posedge clk);
            #1;
            capture(n);
            sd_dq_i = (n == 6) ? rdData : 16'h0000;
        end
        sd_dq_i = 16'h0000;
    endtask

    task automatic checkInitSequence(input string tag);
        logic [NCH-1:0] ackAll;
        logic [3:0]     expCmd;
        ackAll = '0;
        for (int w = 1; w <= 31; w++) begin
            applyStimulus();
            if (w == 19)                 expCmd = CMD_PRECHARGE;
            else if (w >= 20 && w <= 29) expCmd = CMD_REFRESH;
            else if (w == 30)            expCmd = CMD_LOAD_MODE;
            else                         expCmd = CMD_NOP;
            checkOutput($sformatf("%s w%0d cmd", tag, w), snapCmd[2], expCmd);
            if (w == 19) checkOutput({tag, " precharge A10"}, snapAddr[2][10], 1);
            if (w == 30) checkOutput({tag, " mode reg"}, snapAddr[2], 13'h0220);
            ackAll = ackAll | ackOr;
        end
        checkOutput({tag, " no acks"}, ackAll, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        sync    = 1'b0;
        ch_req  = '0;
        ch_we   = '0;
        ch_addr = '0;
        ch_din  = '0;
        ch_ds   = '0;
        sd_dq_i = '0;
        rdData  = '0;
        rrExp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000,
                    3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cmd", {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}, CMD_NOP);
        checkOutput("reset addr/ba", {sd_addr, sd_ba}, 0);
        checkOutput("reset dqm", sd_dqm, 2'b11);
        checkOutput("reset oe", sd_dq_oe, 0);
        checkOutput("reset ack/valid", {ch_ack, ch_valid}, 0);
        checkOutput("reset dout", dout, 0);
        reset = 1'b0;

        checkInitSequence("init");

        applyStimulus();
        checkOutput("idle refresh cmd", snapCmd[2], CMD_REFRESH);
        checkOutput("idle no ack", ackOr, 0);

        // Continuous reads from all channels: seven grants, then a forced refresh.
        ch_req  = 3'b111;
        ch_we   = 3'b000;
        ch_addr = {24'h00_0800, 24'h00_0400, 24'h00_0200};
        for (int i = 0; i < 16; i++) begin
            rdData = 16'h1000 + 16'(i);
            applyStimulus();
            checkOutput($sformatf("rr w%0d ack", i), ackOr, rrExp[i]);
            checkOutput($sformatf("rr w%0d cmd", i), snapCmd[2], (rrExp[i] != 0) ? CMD_ACTIVE : CMD_REFRESH);
            checkOutput($sformatf("rr w%0d valid", i), snapValid[7], rrExp[i]);
            if (rrExp[i] != 0) checkOutput($sformatf("rr w%0d dout", i), snapDout[7], 16'h1000 + 16'(i));
        end
        ch_req = '0;

        ch_req              = 3'b010;
        ch_addr[1*AW +: AW] = 24'h12_3456;
        rdData              = 16'hBEEF;
        applyStimulus();
        checkOutput("rd ack", snapAck[2], 3'b010);
        checkOutput("rd active", snapCmd[2], CMD_ACTIVE);
        checkOutput("rd ba", snapBa[2], 2);
        checkOutput("rd row", snapAddr[2], 13'h0246);
        checkOutput("rd cmd", snapCmd[4], CMD_READ);
        checkOutput("rd col addr", snapAddr[4], 13'h0456);
        checkOutput("rd dqm", snapDqm[4], 2'b00);
        checkOutput("rd dqm after", snapDqm[5], 2'b11);
        checkOutput("rd valid early", snapValid[6], 0);
        checkOutput("rd valid", snapValid[7], 3'b010);
        checkOutput("rd dout", snapDout[7], 16'hBEEF);
        checkOutput("rd valid count", validOr, 3'b010);
        ch_req = '0;

        ch_req              = 3'b001;
        ch_we               = 3'b001;
        ch_addr[0*AW +: AW] = 24'h00_0A03;
        ch_din[0 +: 16]     = 16'hA55A;
        ch_ds[0 +: 2]       = 2'b01;
        applyStimulus();
        checkOutput("wr ack", snapAck[2], 3'b001);
        checkOutput("wr ba/row", {snapBa[2], snapAddr[2]}, {2'd1, 13'h0001});
        checkOutput("wr cmd", snapCmd[4], CMD_WRITE);
        checkOutput("wr col addr", snapAddr[4], 13'h0403);
        checkOutput("wr dqm", snapDqm[4], 2'b10);
        checkOutput("wr oe", snapOe[4], 1);
        checkOutput("wr data", snapDqo[4], 16'hA55A);
        checkOutput("wr oe after", snapOe[5], 0);
        checkOutput("wr dqm after", snapDqm[5], 2'b11);
        checkOutput("wr cmd after", snapCmd[5], CMD_NOP);
        checkOutput("wr no valid", validOr, 0);
        ch_req = '0;

        // Write on ch2 aborted by reset while the WRITE is on the pins.
        ch_req               = 3'b100;
        ch_we                = 3'b100;
        ch_addr[2*AW +: AW]  = 24'h00_0000;
        ch_din[32 +: 16]     = 16'h1234;
        ch_ds[4 +: 2]        = 2'b11;
        @(posedge clk);
        #1 sync = 1'b1;
        @(posedge clk);
        #1 sync = 1'b0;
        @(posedge clk);
        #1 checkOutput("abort ack", ch_ack, 3'b100);
        repeat (2) @(posedge clk);
        #1 checkOutput("abort oe before", sd_dq_oe, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort oe", sd_dq_oe, 0);
        checkOutput("abort cmd", {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}, CMD_NOP);
        checkOutput("abort dqm", sd_dqm, 2'b11);
        reset   = 1'b0;
        validOr = '0;
        ackOr   = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            validOr = validOr | ch_valid;
            ackOr   = ackOr | ch_ack;
        end
        checkOutput("abort no valid", validOr, 0);
        checkOutput("abort no ack", ackOr, 0);

        checkInitSequence("reinit");

        applyStimulus();
        checkOutput("post reinit ack", snapAck[2], 3'b100);
        checkOutput("post reinit cmd", snapCmd[4], CMD_WRITE);
        checkOutput("post reinit addr", snapAddr[4], 13'h0400);
        checkOutput("post reinit data", snapDqo[4], 16'h1234);
        checkOutput("post reinit dqm", snapDqm[4], 2'b00);
        ch_req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
